// File: rtl/tx_packet_scheduler_if.sv
// tx_packet_scheduler_if: descriptor push handshake plus the launch/byte/done
// signals exchanged with the RAM-read and dibit transmit chain.
//
// Handshake: a descriptor transfers on a rising clk edge where
// desc_valid && desc_ready. desc_ready is derived from the registered FIFO
// count. The producer may hold desc_valid with stable data until it is
// accepted; a descriptor offered while desc_ready is low is not taken.
// stream_start, byte_inclk, last_byte and tx_done_in are single-cycle pulses
// without back-pressure.
interface tx_packet_scheduler_if #(
    parameter int AW = 11
);
    logic          desc_valid;
    logic [AW-1:0] desc_start;
    logic [AW-1:0] desc_end;
    logic          desc_ready;
    logic          stream_start;
    logic [AW-1:0] stream_read_start;
    logic [AW-1:0] stream_read_end;
    logic          byte_inclk;
    logic          last_byte;
    logic          tx_done_in;

    // master: everything around the scheduler (packet assembly, stream, serializer)
    modport master (
        output desc_valid, desc_start, desc_end, byte_inclk, tx_done_in,
        input  desc_ready, stream_start, stream_read_start, stream_read_end, last_byte
    );

    // slave: the scheduler itself
    modport slave (
        input  desc_valid, desc_start, desc_end, byte_inclk, tx_done_in,
        output desc_ready, stream_start, stream_read_start, stream_read_end, last_byte
    );
endinterface

// File: rtl/tx_packet_scheduler.sv
// tx_packet_scheduler: queues packet descriptors, launches one memory stream
// per descriptor, flags the final byte, waits for the serializer to drain and
// optionally enforces an inter-frame gap before the next launch.
// Optional feature macro: TX_SCHED_IFG_EN compiles in the GAP state and its
// counter; without it DRAIN returns straight to IDLE and IFG_CYCLES is unused.
// FSM state is exported on dbg_state (IDLE=0, LAUNCH=1, STREAM=2, DRAIN=3, GAP=4).
module tx_packet_scheduler #(
    parameter int RAM_SIZE    = 2048,
    parameter int QUEUE_DEPTH = 4,
    parameter int IFG_CYCLES  = 48
) (
    input  logic                          clk,
    input  logic                          reset_n,
    tx_packet_scheduler_if.slave          bus,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count,
    output logic                          busy,
    output logic                          pkt_sent,
    output logic [2:0]                    dbg_state
);
    localparam int AW = $clog2(RAM_SIZE);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int QW = PW + 1;

    // Length arithmetic relies on natural wrap of the address width, and the
    // FIFO pointers rely on natural wrap of the pointer width.
    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 ||
        RAM_SIZE < 2 || (RAM_SIZE & (RAM_SIZE - 1)) != 0 || IFG_CYCLES < 1) begin : g_bad_params
        $error("tx_packet_scheduler: unsupported parameter values");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t        state, state_next;

    logic [AW-1:0] start_mem [QUEUE_DEPTH];
    logic [AW-1:0] end_mem   [QUEUE_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [QW-1:0] count;
    logic          not_full;
    logic          push, pop;

    logic [AW-1:0] head_start, head_end, head_len;
    logic [CW-1:0] head_bytes;
    logic [CW-1:0] remaining;
    logic          byte_take;
    logic          sent_set;
    logic [AW-1:0] rd_start_q, rd_end_q;

    assign not_full      = (count != QW'(QUEUE_DEPTH));
    assign push          = bus.desc_valid && not_full;
    assign bus.desc_ready = not_full;
    assign queue_count   = count;

    assign head_start = start_mem[rd_ptr];
    assign head_end   = end_mem[rd_ptr];
    assign head_len   = head_end - head_start;
    // start == end means the whole buffer, as the memory streamer treats it
    assign head_bytes = (head_len == '0) ? CW'(RAM_SIZE) : {1'b0, head_len};

    assign bus.stream_start      = (state == S_LAUNCH);
    assign bus.stream_read_start = rd_start_q;
    assign bus.stream_read_end   = rd_end_q;
    assign busy                  = (state != S_IDLE);
    assign dbg_state             = state;

`ifdef TX_SCHED_IFG_EN
    localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    logic [GW-1:0] gap_cnt;

    // Inter-frame gap counter: loaded as the packet completes, counts down in GAP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt <= '0;
        end else if (sent_set) begin
            gap_cnt <= GW'(IFG_CYCLES - 1);
        end else if (state == S_GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
        end
    end
`endif

    // Descriptor storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            start_mem[wr_ptr] <= bus.desc_start;
            end_mem[wr_ptr]   <= bus.desc_end;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + QW'(1);
                2'b01:   count <= count - QW'(1);
                default: count <= count;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Launch addresses, byte countdown and the completion pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_start_q <= '0;
            rd_end_q   <= '0;
            remaining  <= '0;
            pkt_sent   <= 1'b0;
        end else begin
            pkt_sent <= sent_set;
            if (pop) begin
                rd_start_q <= head_start;
                rd_end_q   <= head_end;
                remaining  <= head_bytes;
            end else if (byte_take) begin
                remaining <= remaining - CW'(1);
            end
        end
    end

    // Next state, FIFO pop and the zero-latency final-byte flag
    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        byte_take     = 1'b0;
        sent_set      = 1'b0;
        bus.last_byte = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: state_next = S_STREAM;
            S_STREAM: begin
                if (bus.byte_inclk) begin
                    byte_take = 1'b1;
                    if (remaining == CW'(1)) begin
                        bus.last_byte = 1'b1;
                        state_next    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.tx_done_in) begin
                    sent_set = 1'b1;
`ifdef TX_SCHED_IFG_EN
                    state_next = S_GAP;
`else
                    state_next = S_IDLE;
`endif
                end
            end
            S_GAP: begin
`ifdef TX_SCHED_IFG_EN
                if (gap_cnt == '0) state_next = S_IDLE;
`else
                state_next = S_IDLE;
`endif
            end
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_tx_packet_scheduler.sv
// tb_tx_packet_scheduler: directed bench for tx_packet_scheduler with
// RAM_SIZE=2048, QUEUE_DEPTH=4, IFG_CYCLES=48. Expected launch addresses are
// kept in a scoreboard queue; everything else is hand-computed per step.
module tb_tx_packet_scheduler;
    localparam int RAM_SIZE = 2048;
    localparam int QD       = 4;
    localparam int IFG      = 48;
    localparam int AW       = 11;
    localparam int QW       = 3;
`ifdef TX_SCHED_IFG_EN
    localparam int GAP_LEN    = IFG;
    localparam int POST_STATE = 4;
`else
    localparam int GAP_LEN    = 0;
    localparam int POST_STATE = 0;
`endif

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic [QW-1:0] queue_count;
    logic          busy;
    logic          pkt_sent;
    logic [2:0]    dbg_state;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    logic [2*AW-1:0] exp_q[$];
    logic prev_launch = 1'b0;

    tx_packet_scheduler_if #(.AW(AW)) bus();

    tx_packet_scheduler #(
        .RAM_SIZE    (RAM_SIZE),
        .QUEUE_DEPTH (QD),
        .IFG_CYCLES  (IFG)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .queue_count (queue_count),
        .busy        (busy),
        .pkt_sent    (pkt_sent),
        .dbg_state   (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // scoreboard: every launch must match the oldest accepted descriptor
    always @(negedge clk) begin
        logic [2*AW-1:0] e;
        if (bus.stream_start) begin
            check("launch_one_cycle", prev_launch, 0);
            check("launch_pending", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("read_start", bus.stream_read_start, e[2*AW-1:AW]);
                check("read_end", bus.stream_read_end, e[AW-1:0]);
            end
        end
        prev_launch = bus.stream_start;
    end

    // driver tasks (all start just after a falling edge)
    task automatic push(input int s, input int e, input logic acc);
        bus.desc_valid = 1'b1;
        bus.desc_start = AW'(s);
        bus.desc_end   = AW'(e);
        #1 check("desc_ready", bus.desc_ready, acc);
        if (acc) exp_q.push_back({AW'(s), AW'(e)});
        @(negedge clk);
        bus.desc_valid = 1'b0;
    endtask

    task automatic wait_launch(input string tag);
        int n = 0;
        while (!bus.stream_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_launch_in_time"}, (n < 200), 1);
    endtask

    task automatic send_bytes(input int n);
        int   hits = 0;
        logic lb_final = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            bus.byte_inclk = 1'b1;
            #1;
            if (bus.last_byte) hits++;
            if (i == n) lb_final = bus.last_byte;
        end
        @(negedge clk);
        bus.byte_inclk = 1'b0;
        check("last_byte_on_final", lb_final, 1);
        check("last_byte_hits", hits, 1);
    endtask

    task automatic end_packet(output int sent_cyc);
        bus.tx_done_in = 1'b1;
        @(negedge clk);
        bus.tx_done_in = 1'b0;
        #1 check("pkt_sent_pulse", pkt_sent, 1);
        sent_cyc = cyc;
    endtask

    task automatic wait_idle(input int exp_busy);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("gap_busy_cycles", n, exp_busy);
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        bus.desc_valid = 1'b0;
        bus.desc_start = '0;
        bus.desc_end   = '0;
        bus.byte_inclk = 1'b0;
        bus.tx_done_in = 1'b0;

        // reset values
        #1 reset_n = 1'b0;
        @(negedge clk);
        #1;
        check("rst_desc_ready", bus.desc_ready, 1);
        check("rst_queue_count", queue_count, 0);
        check("rst_stream_start", bus.stream_start, 0);
        check("rst_last_byte", bus.last_byte, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt_sent", pkt_sent, 0);
        check("rst_read_start", bus.stream_read_start, 0);
        check("rst_read_end", bus.stream_read_end, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // single packet 10..14
        push(10, 14, 1);
        #1 check("t1_count_queued", queue_count, 1);
        check("t1_idle_before_launch", busy, 0);
        @(negedge clk);
        #1 check("t1_stream_start", bus.stream_start, 1);
        check("t1_count_popped", queue_count, 0);
        check("t1_busy", busy, 1);
        send_bytes(4);
        #1 check("t1_drain_state", dbg_state, 3);
        check("t1_no_early_sent", pkt_sent, 0);
        end_packet(sent);
        wait_idle(GAP_LEN);
        @(negedge clk);
        #1 check("t1_sent_cleared", pkt_sent, 0);
        check("t1_idle", busy, 0);

        // wrapping length and full-buffer length
        push(2046, 2, 1);
        wait_launch("t2a");
        send_bytes(4);
        end_packet(sent);
        wait_idle(GAP_LEN);
        push(5, 5, 1);
        wait_launch("t2b");
        send_bytes(2048);
        end_packet(sent);
        wait_idle(GAP_LEN);

        // FIFO full: four queued behind a streaming packet, fifth dropped
        push(100, 104, 1);
        wait_launch("t3");
        for (int k = 0; k < 5; k++) begin
            push(200 + 10 * k, 200 + 10 * k + k + 1, (k < 4));
            #1 check("t3_count_fill", queue_count, (k < 4) ? k + 1 : 4);
        end
        check("t3_ready_low_when_full", bus.desc_ready, 0);
        send_bytes(4);
        end_packet(sent);
        wait_idle(GAP_LEN);
        check("t3_count_before_drain", queue_count, 4);
        for (int k = 0; k < 4; k++) begin
            wait_launch("t3q");
            #1 check("t3_count_step", queue_count, 3 - k);
            send_bytes(k + 1);
            end_packet(sent);
            wait_idle(GAP_LEN);
        end

        // push on the same edge IDLE pops
        push(600, 602, 1);
        wait_launch("t4a");
        push(610, 613, 1);
        send_bytes(2);
        end_packet(sent);
        repeat (GAP_LEN) @(negedge clk);
        #1 check("t4_idle_with_one", busy, 0);
        check("t4_count_one", queue_count, 1);
        push(620, 621, 1);
        #1 check("t4_count_unchanged", queue_count, 1);
        check("t4_launch", bus.stream_start, 1);
        check("t4_sent_to_launch_cycles", cyc - sent + 1, GAP_LEN + 2);
        send_bytes(3);
        end_packet(sent);
        wait_idle(GAP_LEN);
        wait_launch("t4c");
        send_bytes(1);
        end_packet(sent);
        wait_idle(GAP_LEN);

        // reset in the middle of a stream with a descriptor queued
        push(300, 308, 1);
        wait_launch("t5");
        push(320, 322, 1);
        bus.byte_inclk = 1'b1;
        repeat (2) @(negedge clk);
        bus.byte_inclk = 1'b0;
        #3 reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_rst_state", dbg_state, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_count", queue_count, 0);
        check("t5_rst_ready", bus.desc_ready, 1);
        check("t5_rst_read_start", bus.stream_read_start, 0);
        check("t5_rst_read_end", bus.stream_read_end, 0);
        check("t5_rst_stream_start", bus.stream_start, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        push(400, 403, 1);
        wait_launch("t5b");
        send_bytes(3);
        end_packet(sent);
        wait_idle(GAP_LEN);

        // spurious tx_done in STREAM, byte_inclk in DRAIN and after completion
        push(500, 503, 1);
        wait_launch("t6");
        @(negedge clk);
        bus.tx_done_in = 1'b1;
        #1 check("t6_no_sent_stream", pkt_sent, 0);
        check("t6_no_last_stream", bus.last_byte, 0);
        @(negedge clk);
        bus.tx_done_in = 1'b0;
        #1 check("t6_still_stream", dbg_state, 2);
        check("t6_no_sent_after", pkt_sent, 0);
        send_bytes(3);
        bus.byte_inclk = 1'b1;
        #1 check("t6_no_last_drain", bus.last_byte, 0);
        @(negedge clk);
        bus.byte_inclk = 1'b0;
        #1 check("t6_still_drain", dbg_state, 3);
        end_packet(sent);
        bus.byte_inclk = 1'b1;
        #1 check("t6_no_last_after", bus.last_byte, 0);
        @(negedge clk);
        bus.byte_inclk = 1'b0;
        #1 check("t6_post_state", dbg_state, POST_STATE);
        check("t6_sent_single", pkt_sent, 0);
        wait_idle((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
        repeat (3) @(negedge clk);
        check("sb_all_launched", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
